// File: rtl/pe_mode_sequencer_if.sv
// Scheduler/GLB <-> sequencer <-> PE signal bundle for one PE slot.
// The slave modport is the sequencer's view; master is the surrounding fabric.
interface pe_mode_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
);
   // job descriptor
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        cfg_mode;
   logic [LEN_W-1:0]  cfg_len;
   // operand stream
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_filter;
   logic [DATA_W-1:0] in_ifmap;
   logic [DATA_W-1:0] in_psum;
   // PE side
   logic [1:0]        pe_mode;
   logic [DATA_W-1:0] pe_filter;
   logic [DATA_W-1:0] pe_ifmap;
   logic [DATA_W-1:0] pe_psum;
   logic [DATA_W-1:0] pe_psum_out;
   // results and status
   logic              res_valid;
   logic [DATA_W-1:0] res_data;
   logic [3:0]        res_addr;
   logic              res_last;
   logic              busy;
   logic              done;
   logic              err;

   modport slave (
      input  cfg_valid, cfg_mode, cfg_len,
      input  in_valid, in_filter, in_ifmap, in_psum,
      input  pe_psum_out,
      output cfg_ready, in_ready,
      output pe_mode, pe_filter, pe_ifmap, pe_psum,
      output res_valid, res_data, res_addr, res_last,
      output busy, done, err
   );

   modport master (
      output cfg_valid, cfg_mode, cfg_len,
      output in_valid, in_filter, in_ifmap, in_psum,
      output pe_psum_out,
      input  cfg_ready, in_ready,
      input  pe_mode, pe_filter, pe_ifmap, pe_psum,
      input  res_valid, res_data, res_addr, res_last,
      input  busy, done, err
   );
endinterface

// File: rtl/pe_mode_sequencer.sv
// Job-level controller for one mode-selectable PE: takes a job descriptor,
// streams operand beats into the PE, inserts mode-safe bubbles on stalls,
// tracks PE pipeline latency and returns tagged results, then pulses done.
module pe_mode_sequencer #(
   parameter int DATA_W     = 32,
   parameter int LEN_W      = 16,
   parameter int SPAD_DEPTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   pe_mode_sequencer_if.slave bus
);

   localparam int ADDR_W = (SPAD_DEPTH > 1) ? $clog2(SPAD_DEPTH) : 1;

   localparam logic [1:0] MODE_FILT  = 2'b00;
   localparam logic [1:0] MODE_IFMAP = 2'b01;
   localparam logic [1:0] MODE_ACC   = 2'b10;
   localparam logic [1:0] MODE_OFF   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   count_q;
   logic               done_q, err_q;

   logic [1:0]         pe_mode_q;
   logic [DATA_W-1:0]  pe_filter_q, pe_ifmap_q, pe_psum_q;

   // scratchpad address shadow; mirrors the PE's own pointer across jobs
   logic [ADDR_W-1:0]  addr_q;

   // stage 0: beat just registered onto pe_*; stage 1: MAC product stage
   logic               s0_valid_q, s0_last_q, s0_acc_q;
   logic [ADDR_W-1:0]  s0_addr_q;
   logic               s1_valid_q, s1_last_q;

   logic               res_valid_q, res_last_q;
   logic [3:0]         res_addr_q;

   logic               cfg_acc, beat_acc, last_beat, job_is_acc;

   assign cfg_acc    = (state_q == IDLE) && bus.cfg_valid;
   assign beat_acc   = (state_q == RUN) && bus.in_valid;
   assign last_beat  = beat_acc && (count_q == len_q - LEN_W'(1));
   assign job_is_acc = (mode_q == MODE_ACC);

   // next-state decode and the mode in force after the coming edge
   always_comb begin
      // NOTE: every variable gets a default before the case so no latch is inferred.
      state_d = state_q;
      mode_d  = cfg_acc ? bus.cfg_mode : mode_q;
      case (state_q)
         IDLE:  if (bus.cfg_valid) begin
                   state_d = ((bus.cfg_mode == MODE_OFF) || (bus.cfg_len == '0)) ? DONE : RUN;
                end
         RUN:   if (last_beat) state_d = DRAIN;
         DRAIN: if (res_valid_q && res_last_q) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state, PE operand registers, latency delay line and status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mode_q      <= MODE_OFF;
         len_q       <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         pe_mode_q   <= MODE_OFF;
         pe_filter_q <= '0;
         pe_ifmap_q  <= '0;
         pe_psum_q   <= '0;
         addr_q      <= '0;
         s0_valid_q  <= 1'b0;
         s0_last_q   <= 1'b0;
         s0_acc_q    <= 1'b0;
         s0_addr_q   <= '0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         res_valid_q <= 1'b0;
         res_last_q  <= 1'b0;
         res_addr_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         mode_q  <= mode_d;
         if (cfg_acc) len_q <= bus.cfg_len;

         if (cfg_acc)       count_q <= '0;
         else if (beat_acc) count_q <= count_q + LEN_W'(1);

         // done/err are high exactly while in DONE; only an illegal mode flags err
         done_q <= (state_d == DONE);
         err_q  <= (state_d == DONE) && (mode_d == MODE_OFF);

         // PE inputs: live beat, else a bubble that keeps the PE state consistent
         if (beat_acc) begin
            pe_mode_q   <= mode_q;
            pe_filter_q <= bus.in_filter;
            pe_ifmap_q  <= bus.in_ifmap;
            pe_psum_q   <= bus.in_psum;
         end else begin
            // MAC bubbles keep the job mode so the PE pipe keeps shifting;
            // accumulate bubbles park on 11 so the PE address pointer holds.
            if (((state_d == RUN) || (state_d == DRAIN)) && (mode_d != MODE_ACC))
               pe_mode_q <= mode_d;
            else
               pe_mode_q <= MODE_OFF;
            pe_filter_q <= '0;
            pe_ifmap_q  <= '0;
            pe_psum_q   <= '0;
         end

         if (beat_acc && job_is_acc) begin
            if (addr_q == ADDR_W'(SPAD_DEPTH - 1)) addr_q <= '0;
            else                                   addr_q <= addr_q + ADDR_W'(1);
         end

         s0_valid_q <= beat_acc;
         s0_last_q  <= last_beat;
         s0_acc_q   <= job_is_acc;
         s0_addr_q  <= addr_q;

         // MAC results need one more edge than scratchpad reads
         s1_valid_q <= s0_valid_q && !s0_acc_q;
         s1_last_q  <= s0_last_q;

         res_valid_q <= (s0_valid_q && s0_acc_q) || s1_valid_q;
         res_last_q  <= (s0_valid_q && s0_acc_q && s0_last_q) || (s1_valid_q && s1_last_q);
         res_addr_q  <= (s0_valid_q && s0_acc_q) ? 4'(s0_addr_q) : 4'd0;
      end
   end

   assign bus.cfg_ready = (state_q == IDLE);
   assign bus.in_ready  = (state_q == RUN);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.pe_mode   = pe_mode_q;
   assign bus.pe_filter = pe_filter_q;
   assign bus.pe_ifmap  = pe_ifmap_q;
   assign bus.pe_psum   = pe_psum_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = bus.pe_psum_out;
   assign bus.res_addr  = res_addr_q;
   assign bus.res_last  = res_last_q;

endmodule
